// File: rtl/control_unit.sv
// control_unit: multicycle CPU control FSM (fetch F0-F2, decode, execute T3-T7, halt).
// All control outputs are flops loaded from a decode of the next state, so they
// line up with the state register and carry no combinational path from inputs.
// Optional feature: define MUL_DIV_EN to execute mul/div; otherwise those opcodes are illegal.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        mem_ready,
  input  logic        stop,
  output logic [31:0] reg_enable,
  output logic [31:0] out_sel,
  output logic [5:0]  ALU_Sel,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        read,
  output logic        write,
  output logic        incPC,
  output logic        conIn,
  output logic        run,
  output logic        illegal
);

  // Bit positions shared by reg_enable and out_sel.
  localparam int unsigned BitHi   = 16;
  localparam int unsigned BitLo   = 17;
  localparam int unsigned BitZhi  = 18;
  localparam int unsigned BitZlo  = 19;
  localparam int unsigned BitPc   = 20;
  localparam int unsigned BitIr   = 21;
  localparam int unsigned BitMdr  = 22;
  localparam int unsigned BitMar  = 23;
  localparam int unsigned BitY    = 24;
  localparam int unsigned BitC    = 25;
  localparam int unsigned BitPcO  = 26;

  typedef enum logic [3:0] {
    StIdle, StF0, StF1, StF2, StDec, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsLd, ClsLdi, ClsSt, ClsAluR, ClsAluI, ClsMulDiv, ClsBr, ClsJr, ClsJal,
    ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIll
  } cls_e;

  typedef struct packed {
    logic [31:0] reg_en;
    logic [31:0] out_sel;
    logic [5:0]  alu_sel;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rin;
    logic        rout;
    logic        ba_out;
    logic        read;
    logic        write;
    logic        inc_pc;
    logic        con_in;
    logic        run;
  } ctrl_t;

  state_e     state_d, state_q, next_fetch;
  cls_e       cls;
  ctrl_t      ctrl_d, ctrl_q;
  logic       illegal_d, illegal_q;
  logic       stop_pend_d, stop_pend_q;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // A stop seen at any time is remembered and honoured at the next F0 entry.
  assign next_fetch = (stop || stop_pend_q) ? StHalt : StF0;

  // Opcode class decode.
  always_comb begin
    cls = ClsIll;
    if (op == 5'd0)                      cls = ClsLd;
    else if (op == 5'd1)                 cls = ClsLdi;
    else if (op == 5'd2)                 cls = ClsSt;
    else if (op >= 5'd3 && op <= 5'd10)  cls = ClsAluR;
    else if (op >= 5'd11 && op <= 5'd13) cls = ClsAluI;
`ifdef MUL_DIV_EN
    else if (op == 5'd14 || op == 5'd15) cls = ClsMulDiv;
`endif
    else if (op == 5'd18)                cls = ClsBr;
    else if (op == 5'd19)                cls = ClsJr;
    else if (op == 5'd20)                cls = ClsJal;
    else if (op == 5'd21)                cls = ClsMfhi;
    else if (op == 5'd22)                cls = ClsMflo;
    else if (op == 5'd24)                cls = ClsNop;
    else if (op == 5'd25)                cls = ClsHalt;
  end

  // Next-state logic, sticky illegal flag and pending-stop latch.
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    stop_pend_d = stop_pend_q | stop;
    unique case (state_q)
      StIdle: state_d = next_fetch;
      StF0:   state_d = StF1;
      StF1:   if (mem_ready) state_d = StF2;
      StF2:   state_d = StDec;
      StDec: begin
        case (cls)
          ClsIll: begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end
          ClsHalt: state_d = StHalt;
          ClsNop:  state_d = next_fetch;
          default: state_d = StT3;
        endcase
      end
      StT3: state_d = (cls == ClsJr || cls == ClsMfhi || cls == ClsMflo) ? next_fetch : StT4;
      StT4: state_d = (cls == ClsJal) ? next_fetch : StT5;
      StT5: state_d = (cls == ClsLd || cls == ClsSt || cls == ClsBr || cls == ClsMulDiv) ?
                      StT6 : next_fetch;
      StT6: begin
        if (cls == ClsLd) begin
          if (mem_ready) state_d = StT7;
        end else if (cls == ClsSt) begin
          state_d = StT7;
        end else begin
          state_d = next_fetch;
        end
      end
      StT7:   if (cls != ClsSt || mem_ready) state_d = next_fetch;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Control word for the state being entered; Zin loads both Z halves.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      StF0: begin
        ctrl_d.out_sel[BitPcO] = 1'b1;
        ctrl_d.reg_en[BitMar]  = 1'b1;
        ctrl_d.inc_pc          = 1'b1;
      end
      StF1: begin
        ctrl_d.read           = 1'b1;
        ctrl_d.reg_en[BitMdr] = 1'b1;
      end
      StF2: begin
        ctrl_d.out_sel[BitMdr] = 1'b1;
        ctrl_d.reg_en[BitIr]   = 1'b1;
      end
      StT3: begin
        case (cls)
          ClsLd, ClsSt, ClsLdi: begin
            ctrl_d.grb = 1'b1; ctrl_d.ba_out = 1'b1; ctrl_d.reg_en[BitY] = 1'b1;
          end
          ClsAluR, ClsAluI: begin
            ctrl_d.grb = 1'b1; ctrl_d.rout = 1'b1; ctrl_d.reg_en[BitY] = 1'b1;
          end
          ClsMulDiv: begin
            ctrl_d.gra = 1'b1; ctrl_d.rout = 1'b1; ctrl_d.reg_en[BitY] = 1'b1;
          end
          ClsBr: begin
            ctrl_d.gra = 1'b1; ctrl_d.rout = 1'b1; ctrl_d.con_in = 1'b1;
          end
          ClsJr: begin
            ctrl_d.gra = 1'b1; ctrl_d.rout = 1'b1; ctrl_d.reg_en[BitPc] = 1'b1;
          end
          // Grb is forced so the register file targets R15 for the link.
          ClsJal: begin
            ctrl_d.out_sel[BitPcO] = 1'b1; ctrl_d.grb = 1'b1; ctrl_d.rin = 1'b1;
          end
          ClsMfhi: begin
            ctrl_d.out_sel[BitHi] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.rin = 1'b1;
          end
          ClsMflo: begin
            ctrl_d.out_sel[BitLo] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.rin = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        case (cls)
          ClsLd, ClsSt, ClsLdi: begin
            ctrl_d.out_sel[BitC] = 1'b1; ctrl_d.alu_sel = 6'd3;
            ctrl_d.reg_en[BitZlo:BitZhi] = 2'b11;
          end
          ClsAluR: begin
            ctrl_d.grc = 1'b1; ctrl_d.rout = 1'b1; ctrl_d.alu_sel = {1'b0, op};
            ctrl_d.reg_en[BitZlo:BitZhi] = 2'b11;
          end
          ClsAluI: begin
            ctrl_d.out_sel[BitC] = 1'b1; ctrl_d.alu_sel = {1'b0, op};
            ctrl_d.reg_en[BitZlo:BitZhi] = 2'b11;
          end
          ClsMulDiv: begin
            ctrl_d.grb = 1'b1; ctrl_d.rout = 1'b1; ctrl_d.alu_sel = {1'b0, op};
            ctrl_d.reg_en[BitZlo:BitZhi] = 2'b11;
          end
          ClsBr: begin
            ctrl_d.out_sel[BitPcO] = 1'b1; ctrl_d.reg_en[BitY] = 1'b1;
          end
          ClsJal: begin
            ctrl_d.gra = 1'b1; ctrl_d.rout = 1'b1; ctrl_d.reg_en[BitPc] = 1'b1;
          end
          default: ;
        endcase
      end
      StT5: begin
        case (cls)
          ClsLd, ClsSt: begin
            ctrl_d.out_sel[BitZlo] = 1'b1; ctrl_d.reg_en[BitMar] = 1'b1;
          end
          ClsLdi, ClsAluR, ClsAluI: begin
            ctrl_d.out_sel[BitZlo] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.rin = 1'b1;
          end
          ClsMulDiv: begin
            ctrl_d.out_sel[BitZlo] = 1'b1; ctrl_d.reg_en[BitLo] = 1'b1;
          end
          ClsBr: begin
            ctrl_d.out_sel[BitC] = 1'b1; ctrl_d.alu_sel = 6'd3;
            ctrl_d.reg_en[BitZlo:BitZhi] = 2'b11;
          end
          default: ;
        endcase
      end
      StT6: begin
        case (cls)
          ClsLd: begin
            ctrl_d.read = 1'b1; ctrl_d.reg_en[BitMdr] = 1'b1;
          end
          ClsSt: begin
            ctrl_d.gra = 1'b1; ctrl_d.rout = 1'b1; ctrl_d.reg_en[BitMdr] = 1'b1;
          end
          ClsBr: begin
            ctrl_d.out_sel[BitZlo] = 1'b1; ctrl_d.reg_en[BitPc] = CON_FF;
          end
          ClsMulDiv: begin
            ctrl_d.out_sel[BitZhi] = 1'b1; ctrl_d.reg_en[BitHi] = 1'b1;
          end
          default: ;
        endcase
      end
      StT7: begin
        case (cls)
          ClsLd: begin
            ctrl_d.out_sel[BitMdr] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.rin = 1'b1;
          end
          ClsSt: ctrl_d.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    ctrl_d.run = (state_d != StIdle) && (state_d != StHalt);
  end

  // State, control word and sticky flags; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign {reg_enable, out_sel, ALU_Sel, Gra, Grb, Grc, Rin, Rout, BAout,
          read, write, incPC, conIn, run} = ctrl_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random and directed instruction streams checked cycle by cycle
// against a per-opcode micro-step table built from the instruction-set rules.
module tb_control_unit;

  logic        clk;
  logic        clr;
  logic [31:0] IR;
  logic        CON_FF;
  logic        mem_ready;
  logic        stop;
  logic [31:0] reg_enable;
  logic [31:0] out_sel;
  logic [5:0]  ALU_Sel;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, read, write, incPC, conIn, run, illegal;

  control_unit u_dut (
    .clk        (clk),
    .clr        (clr),
    .IR         (IR),
    .CON_FF     (CON_FF),
    .mem_ready  (mem_ready),
    .stop       (stop),
    .reg_enable (reg_enable),
    .out_sel    (out_sel),
    .ALU_Sel    (ALU_Sel),
    .Gra        (Gra),
    .Grb        (Grb),
    .Grc        (Grc),
    .Rin        (Rin),
    .Rout       (Rout),
    .BAout      (BAout),
    .read       (read),
    .write      (write),
    .incPC      (incPC),
    .conIn      (conIn),
    .run        (run),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] os;
    logic [5:0]  alu;
    logic gra, grb, grc, rin, rout, ba, rd, wr, inc, con, run, ill;
  } outs_t;

  // Register-bus masks.
  localparam logic [31:0] HI = 32'h0001_0000, LO = 32'h0002_0000, ZH = 32'h0004_0000;
  localparam logic [31:0] ZL = 32'h0008_0000, PC = 32'h0010_0000, IRB = 32'h0020_0000;
  localparam logic [31:0] MDR = 32'h0040_0000, MAR = 32'h0080_0000, Y = 32'h0100_0000;
  localparam logic [31:0] C = 32'h0200_0000, PCO = 32'h0400_0000, Z = ZH | ZL;
  // Flag masks, order {gra, grb, grc, rin, rout, ba, rd, wr, inc, con}.
  localparam logic [9:0] GRA = 10'h200, GRB = 10'h100, GRC = 10'h080, RIN = 10'h040;
  localparam logic [9:0] ROUT = 10'h020, BA = 10'h010, RD = 10'h008, WR = 10'h004;
  localparam logic [9:0] INC = 10'h002, CON = 10'h001;

  localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_R = 3, K_I = 4, K_MD = 5, K_BR = 6;
  localparam int K_JR = 7, K_JAL = 8, K_MFHI = 9, K_MFLO = 10, K_NOP = 11, K_HALT = 12;
  localparam int K_ILL = 13;

  int    n_vec = 0;
  int    n_bad = 0;
  outs_t exp_q[$];
  bit    wt_q[$];
  logic  pending;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o = {reg_enable, out_sel, ALU_Sel, Gra, Grb, Grc, Rin, Rout, BAout,
         read, write, incPC, conIn, run, illegal};
    return o;
  endfunction

  function automatic outs_t mk(input logic [31:0] re, input logic [31:0] os,
                               input logic [5:0] alu, input logic [9:0] fl);
    outs_t o;
    o = '0;
    o.re = re; o.os = os; o.alu = alu;
    {o.gra, o.grb, o.grc, o.rin, o.rout, o.ba, o.rd, o.wr, o.inc, o.con} = fl;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic void push(input outs_t o, input bit w);
    exp_q.push_back(o);
    wt_q.push_back(w);
  endfunction

  function automatic int kind(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v == 0) return K_LD;
    if (v == 1) return K_LDI;
    if (v == 2) return K_ST;
    if (v >= 3 && v <= 10) return K_R;
    if (v >= 11 && v <= 13) return K_I;
    if (v == 14 || v == 15) begin
`ifdef MUL_DIV_EN
      return K_MD;
`else
      return K_ILL;
`endif
    end
    if (v == 18) return K_BR;
    if (v == 19) return K_JR;
    if (v == 20) return K_JAL;
    if (v == 21) return K_MFHI;
    if (v == 22) return K_MFLO;
    if (v == 24) return K_NOP;
    if (v == 25) return K_HALT;
    return K_ILL;
  endfunction

  // Expected per-cycle outputs for one instruction; act 0 = continue, 1 = halt, 2 = illegal.
  function automatic int build(input logic [4:0] op, input logic con);
    int k;
    logic [5:0] a;
    exp_q.delete();
    wt_q.delete();
    k = kind(op);
    a = {1'b0, op};
    push(mk(MAR, PCO, 6'd0, INC), 0);
    push(mk(MDR, 0, 6'd0, RD), 1);
    push(mk(IRB, MDR, 6'd0, 0), 0);
    push(mk(0, 0, 6'd0, 0), 0);
    case (k)
      K_LD, K_ST, K_LDI: begin
        push(mk(Y, 0, 6'd0, GRB | BA), 0);
        push(mk(Z, C, 6'd3, 0), 0);
        if (k == K_LDI) push(mk(0, ZL, 6'd0, GRA | RIN), 0);
        else push(mk(MAR, ZL, 6'd0, 0), 0);
        if (k == K_LD) begin
          push(mk(MDR, 0, 6'd0, RD), 1);
          push(mk(0, MDR, 6'd0, GRA | RIN), 0);
        end else if (k == K_ST) begin
          push(mk(MDR, 0, 6'd0, GRA | ROUT), 0);
          push(mk(0, 0, 6'd0, WR), 1);
        end
      end
      K_R, K_I: begin
        push(mk(Y, 0, 6'd0, GRB | ROUT), 0);
        if (k == K_R) push(mk(Z, 0, a, GRC | ROUT), 0);
        else push(mk(Z, C, a, 0), 0);
        push(mk(0, ZL, 6'd0, GRA | RIN), 0);
      end
      K_MD: begin
        push(mk(Y, 0, 6'd0, GRA | ROUT), 0);
        push(mk(Z, 0, a, GRB | ROUT), 0);
        push(mk(LO, ZL, 6'd0, 0), 0);
        push(mk(HI, ZH, 6'd0, 0), 0);
      end
      K_BR: begin
        push(mk(0, 0, 6'd0, GRA | ROUT | CON), 0);
        push(mk(Y, PCO, 6'd0, 0), 0);
        push(mk(Z, C, 6'd3, 0), 0);
        push(mk(con ? PC : 32'h0, ZL, 6'd0, 0), 0);
      end
      K_JR:   push(mk(PC, 0, 6'd0, GRA | ROUT), 0);
      K_JAL: begin
        push(mk(0, PCO, 6'd0, GRB | RIN), 0);
        push(mk(PC, 0, 6'd0, GRA | ROUT), 0);
      end
      K_MFHI: push(mk(0, HI, 6'd0, GRA | RIN), 0);
      K_MFLO: push(mk(0, LO, 6'd0, GRA | RIN), 0);
      default: ;
    endcase
    if (k == K_HALT) return 1;
    if (k == K_ILL) return 2;
    return 0;
  endfunction

  // lat < 0: random mem_ready; stop_at -1: random stop, -2: none; abort_at: step to reset at.
  task automatic run_instr(input logic [4:0] op, input logic con, input int lat,
                           input int stop_at, input int abort_at,
                           output int ncyc, output int nread, output outs_t last,
                           output logic halted, output outs_t hobs);
    int    act, cnt;
    logic  mr, st;
    outs_t got, h;
    act = build(op, con);
    ncyc = 0; nread = 0; last = '0; halted = 1'b0; hobs = '0;
    for (int j = 0; j < exp_q.size(); j++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        got = sample();
        check($sformatf("op%02h_step%0d", op, j), got, exp_q[j]);
        ncyc++;
        if (got.rd) nread++;
        last = got;
        if (j == 0 && cnt == 0) begin
          IR = {op, 27'($urandom)};
          CON_FF = con;
        end
        if (j == abort_at) begin
          mem_ready = 1'b1;
          stop = 1'b1;
          halted = 1'b1;
          return;
        end
        if (!wt_q[j]) mr = 1'($urandom);
        else if (lat < 0) mr = ($urandom_range(0, 2) != 0) || cnt >= 6;
        else if (j == 1) mr = 1'b1;
        else mr = (cnt >= lat);
        if (stop_at == -1) st = ($urandom_range(0, 15) == 0);
        else st = (j == stop_at && cnt == 0);
        mem_ready = mr;
        stop = st;
        pending = pending | st;
        cnt++;
      end while (wt_q[j] && !mr);
    end
    if (act != 0 || pending) begin
      h = '0;
      h.ill = (act == 2);
      repeat (2) begin
        @(negedge clk);
        hobs = sample();
        check($sformatf("op%02h_halt", op), hobs, h);
        mem_ready = 1'($urandom);
        stop = 1'($urandom);
      end
      halted = 1'b1;
    end
  endtask

  // Hold clr with stop and mem_ready asserted to show reset wins over both.
  task automatic do_reset(input int n);
    clr = 1'b1; stop = 1'b1; mem_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("reset", sample(), '0);
    end
    clr = 1'b0; stop = 1'b0; mem_ready = 1'b0; pending = 1'b0;
  endtask

  int    ncyc, nread;
  outs_t last, hobs;
  logic  halted;
  logic [4:0] rop;
  logic [4:0] dir_ops [8];

  initial begin
    IR = '0; CON_FF = 1'b0; mem_ready = 1'b0; stop = 1'b0; clr = 1'b1; pending = 1'b0;
    do_reset(3);

    // add r1,r2,r3 straight after reset: F0 comes first, seven cycles to T5
    run_instr(5'd3, 1'b0, 0, -2, -1, ncyc, nread, last, halted, hobs);
    check("add_cycles", ncyc, 7);
    check("add_t5", {last.os[19], last.gra, last.rin}, 3'b111);

    // ld with four stall cycles in T6
    run_instr(5'd0, 1'b0, 4, -2, -1, ncyc, nread, last, halted, hobs);
    check("ld_cycles", ncyc, 13);
    check("ld_read_cycles", nread, 6);  // one in F1, five in T6

    run_instr(5'd18, 1'b0, 0, -2, -1, ncyc, nread, last, halted, hobs);
    check("br_nt_pcin", last.re[20], 1'b0);
    run_instr(5'd18, 1'b1, 0, -2, -1, ncyc, nread, last, halted, hobs);
    check("br_t_pcin", last.re[20], 1'b1);

    // sub with stop pulsed in T4 (step 5): completes, then halts
    run_instr(5'd4, 1'b0, 0, 5, -1, ncyc, nread, last, halted, hobs);
    check("sub_cycles", ncyc, 7);
    check("stop_run", hobs.run, 1'b0);
    do_reset(2);

    run_instr(5'd31, 1'b0, 0, -2, -1, ncyc, nread, last, halted, hobs);
    check("ill_flag", hobs.ill, 1'b1);
    do_reset(2);

    run_instr(5'd14, 1'b0, 0, -2, -1, ncyc, nread, last, halted, hobs);
`ifdef MUL_DIV_EN
    check("mul_hi_t6", {last.re[16], last.os[18]}, 2'b11);
`else
    check("mul_illegal", hobs.ill, 1'b1);
`endif
    do_reset(2);

    // reset lands while ld is stalled in T6
    run_instr(5'd0, 1'b0, 10, -2, 7, ncyc, nread, last, halted, hobs);
    do_reset(2);

    dir_ops[0] = 5'd2;  dir_ops[1] = 5'd1;  dir_ops[2] = 5'd12; dir_ops[3] = 5'd19;
    dir_ops[4] = 5'd20; dir_ops[5] = 5'd21; dir_ops[6] = 5'd22; dir_ops[7] = 5'd24;
    for (int i = 0; i < 8; i++) begin
      run_instr(dir_ops[i], 1'b1, 2, -2, -1, ncyc, nread, last, halted, hobs);
    end

    for (int i = 0; i < 400; i++) begin
      rop = 5'($urandom);
      run_instr(rop, 1'($urandom), -1, -1, -1, ncyc, nread, last, halted, hobs);
      if (halted) do_reset($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
